calc1_port_responder: RTL and testbench

Single-port calc1 arithmetic responder: the device side of the calc1 command/data/response interface that the existing calc1 benches drive.
- Accepts a command with operand 1, then operand 2 on the following cycle.
- Executes after a fixed latency and returns a one-cycle response code plus a held result word.
- Serves as the reference responder for bench bring-up and as the per-port execution unit of the calculator.

---
 rtl/calc1_port_responder_if.sv | 25 ++
 rtl/calc1_port_responder.sv | 120 ++++++++++++
 tb/tb_calc1_port_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/calc1_port_responder_if.sv
// calc1_port_responder_if
//   Command/data/response bundle of a single calc1 port.
//   master : issues cmd_in/data_in, observes data_out/out_resp/busy (bench side)
//   slave  : the responder; consumes cmd_in/data_in, drives the results
//   All vectors are numbered MSB-first (bit 0 is the MSB).
interface calc1_port_responder_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4
) ();
  logic [0:CMD_W-1]  cmd_in;    // 0 = no-op
  logic [0:DATA_W-1] data_in;   // op1 on the command cycle, op2 on the next
  logic [0:DATA_W-1] data_out;  // result, held until the next response
  logic [0:1]        out_resp;  // 00 none, 01 ok, 10 over/underflow, 11 invalid
  logic              busy;      // command in flight

  modport master (
    output cmd_in, data_in,
    input  data_out, out_resp, busy
  );

  modport slave (
    input  cmd_in, data_in,
    output data_out, out_resp, busy
  );
endinterface

// File: rtl/calc1_port_responder.sv
// calc1_port_responder
//   Device side of one calc1 port. A non-zero command is accepted together
//   with operand 1, operand 2 follows on the next cycle, and the result is
//   returned EXEC_LAT edges after operand 2 was captured as a one-cycle
//   response code plus a result word that holds until the next response.
//   Commands presented while busy are dropped.
// Ports
//   c_clk    : clock, rising edge
//   reset_n  : synchronous active-low reset, aborts any in-flight command
//   bus      : calc1_port_responder_if.slave (cmd_in, data_in, data_out,
//              out_resp, busy)
module calc1_port_responder #(
  parameter int DATA_W   = 32,
  parameter int CMD_W    = 4,
  parameter int EXEC_LAT = 3    // 1..15
) (
  input  logic                         c_clk,
  input  logic                         reset_n,
  calc1_port_responder_if.slave        bus
);

  localparam logic [0:1] RESP_NONE = 2'b00;
  localparam logic [0:1] RESP_OK   = 2'b01;
  localparam logic [0:1] RESP_OVF  = 2'b10;
  localparam logic [0:1] RESP_INV  = 2'b11;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_LAT - 1);

  typedef enum logic [1:0] {IDLE, OP2, EXEC} state_t;

  state_t            state_q;
  logic [0:CMD_W-1]  cmd_q;
  logic [0:DATA_W-1] op1_q;
  logic [0:DATA_W-1] op2_q;
  logic [0:DATA_W-1] data_q;
  logic [0:1]        resp_q;
  logic              busy_q;
  logic [3:0]        cnt_q;

  // {response code, result word} for the latched command and operands
  logic [0:DATA_W+1] exec_d;

  // Unsigned calc1 arithmetic. Overflow/underflow and invalid commands
  // force the result word to zero. Shifts use only the low 5 bits of op2.
  function automatic logic [0:DATA_W+1] calc(
    input logic [0:CMD_W-1]  cmd,
    input logic [0:DATA_W-1] a,
    input logic [0:DATA_W-1] b
  );
    logic [DATA_W:0] wide;
    logic [4:0]      sh;
    sh   = b[DATA_W-5:DATA_W-1];
    wide = '0;
    calc = {RESP_INV, {DATA_W{1'b0}}};
    case (cmd)
      CMD_W'(1): begin
        wide = {1'b0, a} + {1'b0, b};
        if (wide[DATA_W]) calc = {RESP_OVF, {DATA_W{1'b0}}};
        else              calc = {RESP_OK, wide[DATA_W-1:0]};
      end
      CMD_W'(2): begin
        if (b > a) calc = {RESP_OVF, {DATA_W{1'b0}}};
        else       calc = {RESP_OK, a - b};
      end
      CMD_W'(5): calc = {RESP_OK, a << sh};
      CMD_W'(6): calc = {RESP_OK, a >> sh};
      default:   calc = {RESP_INV, {DATA_W{1'b0}}};
    endcase
  endfunction

  assign exec_d = calc(cmd_q, op1_q, op2_q);

  always_ff @(posedge c_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      data_q  <= '0;
      resp_q  <= RESP_NONE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // response code is a single-cycle pulse; default it back to none
      resp_q <= RESP_NONE;
      case (state_q)
        IDLE: begin
          if (bus.cmd_in != '0) begin
            cmd_q   <= bus.cmd_in;
            op1_q   <= bus.data_in;
            busy_q  <= 1'b1;
            state_q <= OP2;
          end
        end
        OP2: begin
          // cmd_in is a don't-care here; data_in is always operand 2
          op2_q   <= bus.data_in;
          cnt_q   <= CNT_INIT;
          state_q <= EXEC;
        end
        EXEC: begin
          if (cnt_q == 4'd0) begin
            resp_q  <= exec_d[0:1];
            data_q  <= exec_d[2:DATA_W+1];
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out = data_q;
  assign bus.out_resp = resp_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
module tb_calc1_port_responder;

  localparam int DATA_W   = 32;
  localparam int CMD_W    = 4;
  localparam int EXEC_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  calc1_port_responder_if #(.DATA_W(DATA_W), .CMD_W(CMD_W)) bus ();

  calc1_port_responder #(
    .DATA_W(DATA_W), .CMD_W(CMD_W), .EXEC_LAT(EXEC_LAT)
  ) dut (
    .c_clk  (clk),
    .reset_n(rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  r;
    logic [31:0] d;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the calc1 arithmetic rules.
  task automatic model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       output logic [1:0] r, output logic [31:0] d);
    logic [63:0] s;
    s = {32'h0, a} + {32'h0, b};
    case (cmd)
      4'd1: if (s > 64'hFFFF_FFFF) begin r = 2'b10; d = 0; end
            else begin r = 2'b01; d = s[31:0]; end
      4'd2: if (b > a) begin r = 2'b10; d = 0; end
            else begin r = 2'b01; d = a - b; end
      4'd5: begin r = 2'b01; d = a << (b % 32); end
      4'd6: begin r = 2'b01; d = a >> (b % 32); end
      default: begin r = 2'b11; d = 0; end
    endcase
  endtask

  // Issues one command from idle (inputs set just after an edge, so the
  // command is sampled at the next edge T) and checks the response.
  task automatic run_op(input string name, input logic [3:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] er, input logic [31:0] ed,
                        input bit noise, input bit tail);
    bit got;
    int lat;
    bus.cmd_in  = cmd;
    bus.data_in = a;
    tick();                                   // edge T
    chk({name, "_busy_T"}, 64'(bus.busy), 64'd1);
    bus.cmd_in  = noise ? 4'($urandom_range(1, 15)) : 4'd0;
    bus.data_in = b;
    tick();                                   // edge T+1, op2 captured
    got = 0;
    lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      bus.data_in = $urandom;
      bus.cmd_in  = noise ? 4'($urandom_range(1, 15)) : 4'd0;
      tick();
      if (bus.out_resp != 2'b00) begin
        got = 1;
        lat = i;
      end
    end
    chk({name, "_gotresp"}, 64'(got), 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'(EXEC_LAT));
    chk({name, "_resp"}, 64'(bus.out_resp), 64'(er));
    chk({name, "_data"}, 64'(bus.data_out), 64'(ed));
    chk({name, "_busy_end"}, 64'(bus.busy), 64'd0);
    if (tail) begin
      bus.cmd_in  = 0;
      bus.data_in = $urandom;
      tick();
      chk({name, "_resp_pulse"}, 64'(bus.out_resp), 64'd0);
      chk({name, "_data_hold"}, 64'(bus.data_out), 64'(ed));
    end
  endtask

  initial begin
    logic [1:0]  mr;
    logic [31:0] md, ra, rb;
    logic [3:0]  rc;
    int          nresp;

    vecs[0]  = '{"add_carry",  4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'h0};
    vecs[1]  = '{"add_max",    4'd1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 32'hFFFF_FFFF};
    vecs[2]  = '{"add_zero",   4'd1, 32'h0,         32'h0,         2'b01, 32'h0};
    vecs[3]  = '{"sub_7_5",    4'd2, 32'd7,         32'd5,         2'b01, 32'd2};
    vecs[4]  = '{"sub_5_5",    4'd2, 32'd5,         32'd5,         2'b01, 32'd0};
    vecs[5]  = '{"sub_5_7",    4'd2, 32'd5,         32'd7,         2'b10, 32'd0};
    vecs[6]  = '{"sub_0_max",  4'd2, 32'd0,         32'hFFFF_FFFF, 2'b10, 32'd0};
    vecs[7]  = '{"shl_31",     4'd5, 32'd1,         32'd31,        2'b01, 32'h8000_0000};
    vecs[8]  = '{"shr_31",     4'd6, 32'h8000_0000, 32'd31,        2'b01, 32'd1};
    vecs[9]  = '{"shl_0x25",   4'd5, 32'd1,         32'h25,        2'b01, 32'h20};
    vecs[10] = '{"shr_0",      4'd6, 32'hF0F0_F0F0, 32'd0,         2'b01, 32'hF0F0_F0F0};
    vecs[11] = '{"inv_3",      4'd3, 32'd9,         32'd9,         2'b11, 32'd0};
    vecs[12] = '{"inv_15",     4'd15, 32'd1,        32'd2,         2'b11, 32'd0};

    // reset state
    rst_n       = 0;
    bus.cmd_in  = 0;
    bus.data_in = 0;
    tick();
    tick();
    chk("rst_data", 64'(bus.data_out), 64'd0);
    chk("rst_resp", 64'(bus.out_resp), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1;
    tick();
    chk("idle_resp", 64'(bus.out_resp), 64'd0);

    // walking one through add
    for (int k = 0; k <= 30; k++)
      run_op($sformatf("walk%0d", k), 4'd1, 32'd1 << k, 32'd0, 2'b01, 32'd1 << k, 0, 1);

    // boundary table
    for (int i = 0; i < 13; i++)
      run_op(vecs[i].name, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].d, 0, 1);

    // randomized against the model, with ignored commands while busy
    for (int i = 0; i < 40; i++) begin
      rc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
         : 4'(($urandom_range(0, 3) < 2) ? $urandom_range(1, 2) : $urandom_range(5, 6));
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      if (i % 5 == 1) rb = 32'($urandom_range(0, 63));
      model(rc, ra, rb, mr, md);
      run_op($sformatf("rnd%0d", i), rc, ra, rb, mr, md, 1, (i % 3) == 0);
    end
    bus.cmd_in = 0;
    tick();

    // commands while busy are dropped; next command right after response
    bus.cmd_in = 4'd1; bus.data_in = 32'd1;
    tick();                                            // T
    bus.cmd_in = 4'd0; bus.data_in = 32'd2;
    tick();                                            // T+1
    bus.cmd_in = 4'd1; bus.data_in = 32'd100;
    tick();                                            // T+2
    chk("busy_drop_T2", 64'(bus.out_resp), 64'd0);
    bus.cmd_in = 4'd1; bus.data_in = 32'd200;
    tick();                                            // T+3
    chk("busy_drop_T3", 64'(bus.out_resp), 64'd0);
    bus.cmd_in = 4'd2; bus.data_in = 32'd9;
    tick();                                            // T+4
    chk("busy_drop_resp", 64'(bus.out_resp), 64'd1);
    chk("busy_drop_data", 64'(bus.data_out), 64'd3);
    tick();                                            // T+5 new cmd accepted
    chk("next_busy", 64'(bus.busy), 64'd1);
    bus.cmd_in = 4'd0; bus.data_in = 32'd4;
    nresp = 0;
    for (int i = 6; i <= 8; i++) begin
      tick();
      if (bus.out_resp != 0) nresp++;
    end
    chk("next_early", 64'(nresp), 64'd0);
    tick();                                            // T+9
    chk("next_resp", 64'(bus.out_resp), 64'd1);
    chk("next_data", 64'(bus.data_out), 64'd5);
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_resp != 0) nresp++;
    end
    chk("no_stray_resp", 64'(nresp), 64'd0);

    // reset mid-EXEC aborts the command
    bus.cmd_in = 4'd1; bus.data_in = 32'd10;
    tick();                                            // T
    bus.cmd_in = 4'd0; bus.data_in = 32'd20;
    tick();                                            // T+1
    rst_n = 0;
    tick();                                            // T+2
    rst_n = 1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_data", 64'(bus.data_out), 64'd0);
    chk("abort_resp", 64'(bus.out_resp), 64'd0);
    nresp = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_resp != 0 || bus.busy) nresp++;
    end
    chk("abort_silent", 64'(nresp), 64'd0);
    run_op("after_rst", 4'd1, 32'd3, 32'd4, 2'b01, 32'd7, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
